// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline: load-use stalls, redirect
// flushes, memory-wait freeze, EX operand forwarding selects and perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             id_vld,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wren,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             ex_vld_q,   ex_vld_d;
    logic [4:0]       ex_rd_q,    ex_rd_d;
    logic             ex_wren_q,  ex_wren_d;
    logic             ex_load_q,  ex_load_d;
    logic [4:0]       ex_rs1_q,   ex_rs1_d;
    logic [4:0]       ex_rs2_q,   ex_rs2_d;
    logic             ex_use1_q,  ex_use1_d;
    logic             ex_use2_q,  ex_use2_d;
    logic             mem_vld_q,  mem_vld_d;
    logic [4:0]       mem_rd_q,   mem_rd_d;
    logic             mem_wren_q, mem_wren_d;
    logic             mem_load_q, mem_load_d;
    logic             wb_vld_q,   wb_vld_d;
    logic [4:0]       wb_rd_q,    wb_rd_d;
    logic             wb_wren_q,  wb_wren_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic adv_s, hit1_s, hit2_s, load_use_s, redir_s;
    logic stall_s, flush_s, bubble_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Source select for one EX operand; a load still in MEM has no data yet.
    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                           input logic m_vld, input logic m_wren,
                                           input logic m_load, input logic [4:0] m_rd,
                                           input logic w_vld, input logic w_wren,
                                           input logic [4:0] w_rd);
        logic [1:0] r;
        if (use_rs && (rs != 5'd0) && m_vld && m_wren && !m_load && (m_rd == rs)) begin
            r = 2'b01;
        end else if (use_rs && (rs != 5'd0) && w_vld && w_wren && (w_rd == rs)) begin
            r = 2'b10;
        end else begin
            r = 2'b00;
        end
        return r;
    endfunction

    // Hazard detection and pipeline control decisions.
    always_comb begin
        adv_s      = !mem_busy;
        hit1_s     = id_use_rs1 && (id_rs1 != 5'd0) && (id_rs1 == ex_rd_q);
        hit2_s     = id_use_rs2 && (id_rs2 != 5'd0) && (id_rs2 == ex_rd_q);
        load_use_s = id_vld && ex_vld_q && ex_load_q && ex_wren_q && (hit1_s || hit2_s);
        redir_s    = ex_vld_q && ex_redirect;
        stall_s    = 1'b0;
        flush_s    = 1'b0;
        bubble_s   = 1'b0;
        if (mem_busy) begin
            stall_s = 1'b1;
        end else if (redir_s) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
        end else if (load_use_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next-state for the stage trackers and counters.
    always_comb begin
        ex_vld_d   = ex_vld_q;
        ex_rd_d    = ex_rd_q;
        ex_wren_d  = ex_wren_q;
        ex_load_d  = ex_load_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_use1_d  = ex_use1_q;
        ex_use2_d  = ex_use2_q;
        mem_vld_d  = mem_vld_q;
        mem_rd_d   = mem_rd_q;
        mem_wren_d = mem_wren_q;
        mem_load_d = mem_load_q;
        wb_vld_d   = wb_vld_q;
        wb_rd_d    = wb_rd_q;
        wb_wren_d  = wb_wren_q;
        if (adv_s) begin
            wb_vld_d   = mem_vld_q;
            wb_rd_d    = mem_rd_q;
            wb_wren_d  = mem_wren_q;
            mem_vld_d  = ex_vld_q;
            mem_rd_d   = ex_rd_q;
            mem_wren_d = ex_wren_q;
            mem_load_d = ex_load_q;
            if (bubble_s) begin
                ex_vld_d  = 1'b0;
                ex_rd_d   = 5'd0;
                ex_wren_d = 1'b0;
                ex_load_d = 1'b0;
                ex_rs1_d  = 5'd0;
                ex_rs2_d  = 5'd0;
                ex_use1_d = 1'b0;
                ex_use2_d = 1'b0;
            end else begin
                ex_vld_d  = id_vld;
                ex_rd_d   = id_rd;
                ex_wren_d = id_rd_wren;
                ex_load_d = id_is_load;
                ex_rs1_d  = id_rs1;
                ex_rs2_d  = id_rs2;
                ex_use1_d = id_use_rs1;
                ex_use2_d = id_use_rs2;
            end
        end else begin
            ex_vld_d = ex_vld_q;
        end
        stall_cnt_d = sat_inc(stall_cnt_q, stall_s);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_vld_q    <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wren_q   <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            mem_vld_q   <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wren_q  <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_vld_q    <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_wren_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_vld_q    <= ex_vld_d;
            ex_rd_q     <= ex_rd_d;
            ex_wren_q   <= ex_wren_d;
            ex_load_q   <= ex_load_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_use1_q   <= ex_use1_d;
            ex_use2_q   <= ex_use2_d;
            mem_vld_q   <= mem_vld_d;
            mem_rd_q    <= mem_rd_d;
            mem_wren_q  <= mem_wren_d;
            mem_load_q  <= mem_load_d;
            wb_vld_q    <= wb_vld_d;
            wb_rd_q     <= wb_rd_d;
            wb_wren_q   <= wb_wren_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_if  = stall_s;
    assign stall_id  = stall_s;
    assign flush_id  = flush_s;
    assign bubble_ex = bubble_s;
    assign freeze    = mem_busy;
    assign fwd_a_sel = fwd_sel(ex_use1_q, ex_rs1_q, mem_vld_q, mem_wren_q, mem_load_q,
                               mem_rd_q, wb_vld_q, wb_wren_q, wb_rd_q);
    assign fwd_b_sel = fwd_sel(ex_use2_q, ex_rs2_q, mem_vld_q, mem_wren_q, mem_load_q,
                               mem_rd_q, wb_vld_q, wb_wren_q, wb_rd_q);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second 4-bit-counter instance shares the
// stimulus so counter saturation can be observed.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_vld = 1'b0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rd_wren = 1'b0, id_is_load = 1'b0;
    logic        ex_redirect = 1'b0, mem_busy = 1'b0;

    logic        stall_if, stall_id, flush_id, bubble_ex, freeze;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s4_if, s4_id, f4_id, b4_ex, z4;
    logic [1:0]  a4_sel, b4_sel;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd_wren(id_rd_wren), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .freeze(freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd_wren(id_rd_wren), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .stall_if(s4_if), .stall_id(s4_id), .flush_id(f4_id),
        .bubble_ex(b4_ex), .freeze(z4), .fwd_a_sel(a4_sel), .fwd_b_sel(b4_sel),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control vector order: {stall_if, stall_id, flush_id, bubble_ex, freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {11'd0, stall_if, stall_id, flush_id, bubble_ex, freeze}, {11'd0, exp});
    endtask

    task automatic set_id(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wren, input logic load);
        id_vld = vld; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_rd_wren = wren; id_is_load = load;
    endtask

    task automatic nop_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctl("reset_ctl", 5'b00000);
        chk("reset_fwd", {12'd0, fwd_a_sel, fwd_b_sel}, 16'd0);
        chk("reset_cnt", stall_cnt | flush_cnt, 16'd0);

        // 1. Load-use: lw x5 then add x6,x5,x1
        @(negedge clk); set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1); #1;
        chk_ctl("lu_lw_in_id", 5'b00000);
        @(negedge clk); set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        chk_ctl("lu_stall", 5'b11010);
        @(negedge clk); #1;
        chk_ctl("lu_one_cycle", 5'b00000);
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        @(negedge clk); nop_id(); #1;
        chk("lu_fwd_a", {14'd0, fwd_a_sel}, 16'd2);
        chk("lu_fwd_b", {14'd0, fwd_b_sel}, 16'd0);

        // 2. add x3 ; sub x4,x3,x3 -> MEM forward both operands
        @(negedge clk); set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #1;
        @(negedge clk); set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
        chk_ctl("alu_no_stall", 5'b00000);
        @(negedge clk); set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #1;
        chk("alu_fwd_ab", {12'd0, fwd_a_sel, fwd_b_sel}, 16'b0101);
        // add x3 ; and x8,x1,x2 ; or x7,x3,x0
        @(negedge clk); set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); #1;
        @(negedge clk); set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); #1;
        @(negedge clk); nop_id(); #1;
        chk("wb_fwd_ab", {12'd0, fwd_a_sel, fwd_b_sel}, 16'b1000);

        // 3. Redirect beats load-use
        @(negedge clk); set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1); #1;
        @(negedge clk); set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_redirect = 1'b1; #1;
        chk_ctl("redir_ctl", 5'b00110);
        @(negedge clk); #1;
        chk_ctl("redir_ex_invalid", 5'b00000);
        chk("redir_flush_cnt", flush_cnt, 16'd1);
        ex_redirect = 1'b0;

        // 4. Memory wait with pending redirect
        @(negedge clk); set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); #1;
        @(negedge clk); nop_id(); ex_redirect = 1'b1; mem_busy = 1'b1; #1;
        chk_ctl("busy_c1", 5'b11001);
        @(negedge clk); #1;
        chk_ctl("busy_c2", 5'b11001);
        @(negedge clk); #1;
        chk_ctl("busy_c3", 5'b11001);
        @(negedge clk); mem_busy = 1'b0; #1;
        chk_ctl("busy_release_flush", 5'b00110);
        chk("busy_stall_cnt", stall_cnt, 16'd4);
        @(negedge clk); ex_redirect = 1'b0; #1;
        chk("busy_flush_cnt", flush_cnt, 16'd2);

        // 5. MEM beats WB on x9; x0 never stalls or forwards
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk); set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        @(negedge clk); set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        @(negedge clk); nop_id(); #1;
        chk("prio_mem_over_wb", {14'd0, fwd_a_sel}, 16'd1);
        @(negedge clk); set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        @(negedge clk); set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); #1;
        chk_ctl("x0_no_stall", 5'b00000);
        @(negedge clk); nop_id(); #1;
        chk("x0_no_fwd", {12'd0, fwd_a_sel, fwd_b_sel}, 16'd0);

        // 6. Saturation of the 4-bit instance (starts at 4), then reset mid-stall
        mem_busy = 1'b1;
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        chk("sat_reach_15", {12'd0, stall_cnt4}, 16'd15);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        chk("sat_hold_15", {12'd0, stall_cnt4}, 16'd15);
        chk("wide_no_sat", stall_cnt, 16'd18);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mem_busy = 1'b0; #1;
        chk_ctl("rst_mid_stall_ctl", 5'b00000);
        chk("rst_cnt", stall_cnt | flush_cnt, 16'd0);
        chk("rst_cnt4", {8'd0, stall_cnt4, flush_cnt4}, 16'd0);
        chk("rst_fwd", {12'd0, fwd_a_sel, fwd_b_sel}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
